// File: rtl/nubus_slave.sv
// NuBus slave controller: decodes slot-space START cycles, runs a valid/ready
// access on the local port and terminates with a one-cycle ACK plus status.
module nubus_slave #(
  parameter bit          SUPER_EN = 1'b0,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        nub_clkn,
  input  logic        nub_resetn,
  input  logic        nub_startn,
  input  logic        nub_ackn,
  input  logic [3:0]  nub_idn,
  input  logic        nub_tm1n,
  input  logic        nub_tm0n,
  input  logic [31:0] nub_adn,
  input  logic        busy_i,
  input  logic        mem_ready,
  input  logic        mem_err,
  input  logic [31:0] mem_rdata,
  output logic        mem_valid,
  output logic        mem_write,
  output logic [23:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  output logic        ack_o,
  output logic [1:0]  stat_o,
  output logic        ad_oe_o,
  output logic [31:0] rd_data_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_MEM,
    S_ACK
  } state_t;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_ERR   = 2'b01;
  localparam logic [1:0] ST_TMO   = 2'b10;
  localparam logic [1:0] ST_RETRY = 2'b11;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_valid_q, mem_valid_d;
  logic        mem_write_q, mem_write_d;
  logic [23:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        ack_q, ack_d;
  logic [1:0]  stat_q, stat_d;
  logic        ad_oe_q, ad_oe_d;
  logic [31:0] rd_data_q, rd_data_d;

  logic [31:0] ad;
  logic        start, ack_seen, match, reserved;
  logic [3:0]  slot, be_dec;
  logic [7:0]  cnt_inc;

  always_comb begin
    ad       = ~nub_adn;
    start    = ~nub_startn;
    ack_seen = ~nub_ackn;
    slot     = ~nub_idn;
    match    = ((ad[31:28] == 4'hF) && (ad[27:24] == slot)) ||
               (SUPER_EN && (ad[31:28] == slot));
    reserved = 1'b0;
    be_dec   = '0;
    if (!nub_tm0n) begin
      be_dec = 4'b0001 << ad[1:0];
    end else begin
      unique case (ad[1:0])
        2'b00:   be_dec = 4'b1111;
        2'b01:   be_dec = 4'b0011;
        2'b11:   be_dec = 4'b1100;
        default: reserved = 1'b1;
      endcase
    end
    cnt_inc = cnt_q + 8'd1;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_valid_d = mem_valid_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    ack_d       = 1'b0;
    stat_d      = stat_q;
    ad_oe_d     = 1'b0;
    rd_data_d   = rd_data_q;

    unique case (state_q)
      S_IDLE: begin
        // A START carrying ACK in the same cycle is an attention cycle.
        if (start && !ack_seen && match) begin
          mem_addr_d  = ad[23:0];
          mem_write_d = ~nub_tm1n;
          mem_be_d    = be_dec;
          if (busy_i) begin
            stat_d  = ST_RETRY;
            ack_d   = 1'b1;
            state_d = S_ACK;
          end else if (reserved) begin
            stat_d  = ST_ERR;
            ack_d   = 1'b1;
            state_d = S_ACK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (mem_write_q) mem_wdata_d = ad;
        cnt_d       = '0;
        mem_valid_d = 1'b1;
        state_d     = S_MEM;
      end
      S_MEM: begin
        cnt_d = cnt_inc;
        if (mem_ready) begin
          if (!mem_write_q) rd_data_d = mem_rdata;
          stat_d      = mem_err ? ST_ERR : ST_OK;
          ad_oe_d     = !mem_write_q && !mem_err;
          ack_d       = 1'b1;
          mem_valid_d = 1'b0;
          state_d     = S_ACK;
        end else if (cnt_inc == TO_LIM) begin
          stat_d      = ST_TMO;
          ack_d       = 1'b1;
          mem_valid_d = 1'b0;
          state_d     = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        mem_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mem_valid_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      ack_q       <= 1'b0;
      stat_q      <= '0;
      ad_oe_q     <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_valid_q <= mem_valid_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      ack_q       <= ack_d;
      stat_q      <= stat_d;
      ad_oe_q     <= ad_oe_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign ack_o     = ack_q;
  assign stat_o    = stat_q;
  assign ad_oe_o   = ad_oe_q;
  assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_nubus_slave.sv
// Self-checking bench for nubus_slave: directed scenarios plus randomized
// transactions checked against a transaction-level model.
module tb_nubus_slave;

  localparam int unsigned TO   = 4;
  localparam logic [3:0]  SLOT = 4'h3;

  logic        nub_clkn = 1'b0;
  logic        nub_resetn;
  logic        nub_startn, nub_ackn, nub_tm1n, nub_tm0n;
  logic [3:0]  nub_idn;
  logic [31:0] nub_adn;
  logic        busy_i, mem_ready, mem_err;
  logic [31:0] mem_rdata;
  logic        mem_valid, mem_write, ack_o, ad_oe_o;
  logic [23:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, rd_data_o;
  logic [1:0]  stat_o;

  nubus_slave #(.SUPER_EN(1'b0), .TIMEOUT(TO)) dut (
    .nub_clkn(nub_clkn), .nub_resetn(nub_resetn), .nub_startn(nub_startn),
    .nub_ackn(nub_ackn), .nub_idn(nub_idn), .nub_tm1n(nub_tm1n),
    .nub_tm0n(nub_tm0n), .nub_adn(nub_adn), .busy_i(busy_i),
    .mem_ready(mem_ready), .mem_err(mem_err), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .ack_o(ack_o), .stat_o(stat_o),
    .ad_oe_o(ad_oe_o), .rd_data_o(rd_data_o)
  );

  always #5 nub_clkn = ~nub_clkn;

  int n_checks = 0;
  int n_pass   = 0;

  // Observations of one transaction (k = edges after the START edge).
  int          obs_ack_cnt, obs_ack_at, obs_oe_cnt, obs_mv_cnt;
  logic [1:0]  obs_stat;
  logic        obs_oe_at_ack, obs_write;
  logic [31:0] obs_rd, obs_wdata;
  logic [23:0] obs_addr;
  logic [3:0]  obs_be;

  // Model expectations.
  bit          exp_ack, exp_oe;
  int          exp_ack_at, exp_mv_cnt;
  logic [1:0]  exp_stat;
  logic [3:0]  exp_be;
  logic [31:0] exp_rd;
  logic [31:0] model_rd = '0;

  task automatic idle_bus();
    nub_startn = 1'b1; nub_ackn = 1'b1; nub_tm1n = 1'b1; nub_tm0n = 1'b1;
    nub_adn = '1; busy_i = 1'b0; mem_ready = 1'b0; mem_err = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic model(input logic [31:0] addr, input bit rd, input bit byt,
                       input bit busy, input bit attn, input int unsigned dly,
                       input bit err, input logic [31:0] rdata);
    logic [1:0] lane;
    exp_ack = 0; exp_mv_cnt = 0; exp_oe = 0; exp_ack_at = -1;
    exp_stat = 2'b00; exp_be = 4'h0;
    lane = addr[1:0];
    if (addr[31:28] != 4'hF || addr[27:24] != SLOT || attn) return;
    if (byt)             exp_be = 4'(1 << lane);
    else if (lane == 0)  exp_be = 4'hF;
    else if (lane == 1)  exp_be = 4'h3;
    else if (lane == 3)  exp_be = 4'hC;
    exp_ack = 1;
    if (busy) begin
      exp_ack_at = 0; exp_stat = 2'b11;
    end else if (!byt && lane == 2) begin
      exp_ack_at = 0; exp_stat = 2'b01;
    end else if (dly < TO) begin
      exp_ack_at = 2 + int'(dly); exp_stat = err ? 2'b01 : 2'b00;
      exp_mv_cnt = int'(dly) + 1;
      if (rd) model_rd = rdata;
      exp_oe = rd && !err;
    end else begin
      exp_ack_at = 1 + int'(TO); exp_stat = 2'b10; exp_mv_cnt = int'(TO);
    end
    exp_rd = model_rd;
  endtask

  task automatic do_txn(input logic [31:0] addr, input bit rd, input bit byt,
                        input logic [31:0] wdata, input bit busy, input bit attn,
                        input int unsigned dly, input bit err,
                        input logic [31:0] rdata);
    bit rdy;
    obs_ack_cnt = 0; obs_ack_at = -1; obs_oe_cnt = 0; obs_mv_cnt = 0;
    obs_stat = 'x; obs_oe_at_ack = 1'bx; obs_rd = 'x;
    obs_addr = 'x; obs_be = 'x; obs_write = 1'bx; obs_wdata = 'x;
    for (int k = 0; k <= 10; k++) begin
      @(negedge nub_clkn);
      if (k == 0) begin
        nub_startn = 1'b0; nub_ackn = ~attn; nub_adn = ~addr;
        nub_tm1n = rd; nub_tm0n = ~byt; busy_i = busy;
      end else if (k == 1) begin
        nub_startn = 1'b1; nub_ackn = 1'b1; nub_adn = ~wdata;
        nub_tm1n = 1'b1; nub_tm0n = 1'b1; busy_i = 1'b0;
      end else if (k == 2) begin
        nub_adn = '1;
      end
      rdy = (k == 2 + int'(dly));
      mem_ready = rdy;
      mem_err   = rdy && err;
      mem_rdata = rdy ? rdata : $urandom;
      @(posedge nub_clkn); #1;
      if (ack_o) begin
        obs_ack_cnt++; obs_ack_at = k; obs_stat = stat_o;
        obs_oe_at_ack = ad_oe_o; obs_rd = rd_data_o;
      end
      if (ad_oe_o) obs_oe_cnt++;
      if (mem_valid) begin
        if (obs_mv_cnt == 0) begin
          obs_addr = mem_addr; obs_be = mem_be;
          obs_write = mem_write; obs_wdata = mem_wdata;
        end
        obs_mv_cnt++;
      end
    end
    @(negedge nub_clkn);
    idle_bus();
  endtask

  task automatic test_reset();
    idle_bus();
    nub_idn = ~SLOT;
    nub_resetn = 1'b0;
    repeat (3) @(posedge nub_clkn);
    #1;
    n_checks++;
    if ({mem_valid, mem_write, mem_addr, mem_be, mem_wdata, ack_o, stat_o,
         ad_oe_o, rd_data_o} !== '0)
      $display("FAIL reset_outputs: got valid=%b ack=%b be=%h rd=%h, want all zero",
               mem_valid, ack_o, mem_be, rd_data_o);
    else n_pass++;
    @(negedge nub_clkn);
    nub_resetn = 1'b1;
    repeat (2) @(negedge nub_clkn);
  endtask

  task automatic test_word_read();
    model(32'hF3000100, 1, 0, 0, 0, 0, 0, 32'hDEADBEEF);
    do_txn(32'hF3000100, 1, 0, '0, 0, 0, 0, 0, 32'hDEADBEEF);
    n_checks++;
    if (obs_addr !== 24'h000100 || obs_be !== 4'hF || obs_write !== 1'b0)
      $display("FAIL word_read_req: addr=%h be=%h wr=%b, want 000100 f 0",
               obs_addr, obs_be, obs_write);
    else n_pass++;
    n_checks++;
    if (obs_ack_cnt !== 1 || obs_ack_at !== 2 || obs_stat !== 2'b00)
      $display("FAIL word_read_ack: cnt=%0d at=%0d stat=%b, want 1 2 00",
               obs_ack_cnt, obs_ack_at, obs_stat);
    else n_pass++;
    n_checks++;
    if (obs_oe_at_ack !== 1'b1 || obs_oe_cnt !== 1 || obs_rd !== 32'hDEADBEEF)
      $display("FAIL word_read_data: oe=%b oecnt=%0d rd=%h, want 1 1 deadbeef",
               obs_oe_at_ack, obs_oe_cnt, obs_rd);
    else n_pass++;
  endtask

  task automatic test_byte_write();
    model(32'hF3000002, 0, 1, 0, 0, 1, 0, 32'h0);
    do_txn(32'hF3000002, 0, 1, 32'h000000A5, 0, 0, 1, 0, 32'h0);
    n_checks++;
    if (obs_write !== 1'b1 || obs_be !== 4'b0100 || obs_wdata !== 32'h000000A5)
      $display("FAIL byte_write_req: wr=%b be=%b wdata=%h, want 1 0100 000000a5",
               obs_write, obs_be, obs_wdata);
    else n_pass++;
    n_checks++;
    if (obs_ack_at !== 3 || obs_stat !== 2'b00 || obs_oe_cnt !== 0)
      $display("FAIL byte_write_ack: at=%0d stat=%b oecnt=%0d, want 3 00 0",
               obs_ack_at, obs_stat, obs_oe_cnt);
    else n_pass++;
  endtask

  task automatic test_ignored();
    do_txn(32'hF4000000, 1, 0, '0, 0, 0, 0, 0, 32'h1);
    n_checks++;
    if (obs_mv_cnt !== 0 || obs_ack_cnt !== 0)
      $display("FAIL other_slot: mv=%0d ack=%0d, want 0 0", obs_mv_cnt, obs_ack_cnt);
    else n_pass++;
    do_txn(32'hF3000000, 1, 0, '0, 0, 1, 0, 0, 32'h2);
    n_checks++;
    if (obs_mv_cnt !== 0 || obs_ack_cnt !== 0)
      $display("FAIL attention: mv=%0d ack=%0d, want 0 0", obs_mv_cnt, obs_ack_cnt);
    else n_pass++;
  endtask

  task automatic test_terminations();
    do_txn(32'hF3000010, 1, 0, '0, 1, 0, 0, 0, 32'h3);
    n_checks++;
    if (obs_ack_cnt !== 1 || obs_ack_at !== 0 || obs_stat !== 2'b11 || obs_mv_cnt !== 0)
      $display("FAIL busy: cnt=%0d at=%0d stat=%b mv=%0d, want 1 0 11 0",
               obs_ack_cnt, obs_ack_at, obs_stat, obs_mv_cnt);
    else n_pass++;
    do_txn(32'hF3000012, 0, 0, 32'h5, 0, 0, 0, 0, 32'h0);
    n_checks++;
    if (obs_ack_at !== 0 || obs_stat !== 2'b01 || obs_mv_cnt !== 0)
      $display("FAIL reserved_size: at=%0d stat=%b mv=%0d, want 0 01 0",
               obs_ack_at, obs_stat, obs_mv_cnt);
    else n_pass++;
    do_txn(32'hF3000020, 1, 0, '0, 0, 0, 9, 0, 32'h4);
    n_checks++;
    if (obs_ack_at !== 5 || obs_stat !== 2'b10 || obs_mv_cnt !== 4 || obs_oe_cnt !== 0)
      $display("FAIL timeout: at=%0d stat=%b mv=%0d oe=%0d, want 5 10 4 0",
               obs_ack_at, obs_stat, obs_mv_cnt, obs_oe_cnt);
    else n_pass++;
    // Ready on the very cycle the counter expires must win over the timeout.
    model(32'hF3000024, 1, 0, 0, 0, 3, 0, 32'h600D600D);
    do_txn(32'hF3000024, 1, 0, '0, 0, 0, 3, 0, 32'h600D600D);
    n_checks++;
    if (obs_ack_at !== 5 || obs_stat !== 2'b00 || obs_rd !== 32'h600D600D)
      $display("FAIL ready_vs_timeout: at=%0d stat=%b rd=%h, want 5 00 600d600d",
               obs_ack_at, obs_stat, obs_rd);
    else n_pass++;
    model(32'hF3000030, 1, 0, 0, 0, 0, 1, 32'hBAD0BAD0);
    do_txn(32'hF3000030, 1, 0, '0, 0, 0, 0, 1, 32'hBAD0BAD0);
    n_checks++;
    if (obs_stat !== 2'b01 || obs_oe_cnt !== 0 || obs_ack_at !== 2)
      $display("FAIL mem_err: stat=%b oe=%0d at=%0d, want 01 0 2",
               obs_stat, obs_oe_cnt, obs_ack_at);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int waited = 0;
    int acks = 0;
    @(negedge nub_clkn);
    nub_startn = 1'b0; nub_adn = ~32'hF3000040; nub_tm1n = 1'b1; nub_tm0n = 1'b1;
    @(negedge nub_clkn);
    idle_bus();
    while (!mem_valid && waited < 5) begin
      @(posedge nub_clkn); #1; waited++;
    end
    n_checks++;
    if (mem_valid !== 1'b1) $display("FAIL mid_reset_enter_mem: mem_valid=%b, want 1", mem_valid);
    else n_pass++;
    #2;
    nub_resetn = 1'b0;
    #1;
    n_checks++;
    if (mem_valid !== 1'b0 || ack_o !== 1'b0)
      $display("FAIL mid_reset_async: valid=%b ack=%b, want 0 0", mem_valid, ack_o);
    else n_pass++;
    @(negedge nub_clkn);
    nub_resetn = 1'b1;
    model_rd = '0;
    repeat (8) begin
      @(posedge nub_clkn); #1;
      if (ack_o || mem_valid) acks++;
    end
    n_checks++;
    if (acks !== 0) $display("FAIL mid_reset_quiet: activity=%0d, want 0", acks);
    else n_pass++;
    model(32'hF3000044, 1, 0, 0, 0, 1, 0, 32'h12345678);
    do_txn(32'hF3000044, 1, 0, '0, 0, 0, 1, 0, 32'h12345678);
    n_checks++;
    if (obs_ack_cnt !== 1 || obs_ack_at !== 3 || obs_stat !== 2'b00 || obs_rd !== 32'h12345678)
      $display("FAIL after_reset_txn: cnt=%0d at=%0d stat=%b rd=%h, want 1 3 00 12345678",
               obs_ack_cnt, obs_ack_at, obs_stat, obs_rd);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] addr, wdata, rdata;
    bit rd, byt, busy, attn, err;
    int unsigned dly;
    for (int i = 0; i < 40; i++) begin
      addr  = $urandom;
      if ($urandom_range(3) != 0) addr[31:24] = 8'hF3;
      wdata = $urandom; rdata = $urandom;
      rd    = 1'($urandom); byt = 1'($urandom);
      busy  = ($urandom_range(7) == 0); attn = ($urandom_range(7) == 0);
      err   = ($urandom_range(3) == 0); dly  = $urandom_range(5);
      model(addr, rd, byt, busy, attn, dly, err, rdata);
      do_txn(addr, rd, byt, wdata, busy, attn, dly, err, rdata);
      n_checks++;
      if (obs_ack_cnt !== int'(exp_ack) || obs_mv_cnt !== exp_mv_cnt)
        $display("FAIL rand%0d_count: ack=%0d mv=%0d, want %0d %0d",
                 i, obs_ack_cnt, obs_mv_cnt, exp_ack, exp_mv_cnt);
      else n_pass++;
      if (exp_ack) begin
        n_checks++;
        if (obs_ack_at !== exp_ack_at || obs_stat !== exp_stat ||
            obs_oe_at_ack !== exp_oe || obs_oe_cnt !== int'(exp_oe) || obs_rd !== exp_rd)
          $display("FAIL rand%0d_ack: at=%0d stat=%b oe=%b rd=%h, want %0d %b %b %h",
                   i, obs_ack_at, obs_stat, obs_oe_at_ack, obs_rd,
                   exp_ack_at, exp_stat, exp_oe, exp_rd);
        else n_pass++;
      end
      if (exp_mv_cnt > 0) begin
        n_checks++;
        if (obs_addr !== addr[23:0] || obs_be !== exp_be || obs_write !== !rd ||
            (!rd && obs_wdata !== wdata))
          $display("FAIL rand%0d_req: addr=%h be=%b wr=%b wd=%h, want %h %b %b %h",
                   i, obs_addr, obs_be, obs_write, obs_wdata,
                   addr[23:0], exp_be, !rd, wdata);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_byte_write();
    test_ignored();
    test_terminations();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
